// File: rtl/alif2_ctrl.sv
// alif2_ctrl: supervisory controller for a vehicle's on-board computer and drive enable.
//   - shut_off_computer rises one cycle after an overheat sample. After the overheat
//     clears it stays high for HOLD_CYCLES+1 more cycles. A new overheat during that
//     time restarts the hold.
//   - keep_driving and drive_state follow arrived / gas_tank_empty. arrived has priority.
//   - overheat_count counts rising edges of cpu_overheated and stops at its maximum value.
// Optional macro ALIF2_SYNC_EN adds a 2-flop synchronizer on each input. Latency is then 3 cycles.
module alif2_ctrl #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_overheated,
  input  logic             arrived,
  input  logic             gas_tank_empty,
  output logic             shut_off_computer,
  output logic             keep_driving,
  output logic [1:0]       drive_state,
  output logic [CNT_W-1:0] overheat_count
);

  // Hold counter is at least one bit wide, so HOLD_CYCLES=0 still gives a legal vector.
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_RESET_STOP = 2'd0,
    ST_DRIVING    = 2'd1,
    ST_ARRIVED    = 2'd2,
    ST_NO_GAS     = 2'd3
  } drive_state_t;

  logic w_oh;
  logic w_ar;
  logic w_ge;

`ifdef ALIF2_SYNC_EN
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;

  // Two-flop synchronizer on each input; the logic below sees only the second stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= {cpu_overheated, arrived, gas_tank_empty};
      r_sync2 <= r_sync1;
    end
  end

  assign {w_oh, w_ar, w_ge} = r_sync2;
`else
  assign w_oh = cpu_overheated;
  assign w_ar = arrived;
  assign w_ge = gas_tank_empty;
`endif

  drive_state_t     r_state;
  drive_state_t     w_state_next;
  logic             r_keep;
  logic             w_keep_next;
  logic             r_shut;
  logic             w_shut_next;
  logic [HW-1:0]    r_hold;
  logic [HW-1:0]    w_hold_next;
  logic             r_prev_oh;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_rise;

  // State and output registers. Reset clears everything, including a pending hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_RESET_STOP;
      r_keep    <= 1'b0;
      r_shut    <= 1'b0;
      r_hold    <= '0;
      r_prev_oh <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_keep    <= w_keep_next;
      r_shut    <= w_shut_next;
      r_hold    <= w_hold_next;
      r_prev_oh <= w_oh;
      r_cnt     <= w_cnt_next;
    end
  end

  // Next drive state is set every cycle by the inputs. arrived wins over an empty tank.
  always_comb begin
    w_state_next = ST_DRIVING;
    case ({w_ar, w_ge})
      2'b00:   w_state_next = ST_DRIVING;
      2'b01:   w_state_next = ST_NO_GAS;
      2'b10:   w_state_next = ST_ARRIVED;
      2'b11:   w_state_next = ST_ARRIVED;
      default: w_state_next = ST_RESET_STOP;
    endcase
    w_keep_next = (w_state_next == ST_DRIVING);
  end

  // Shut-off hold: overheat reloads the counter. Once the overheat clears, the counter
  // counts down to zero, and the output drops on the cycle it reads zero.
  always_comb begin
    w_shut_next = r_shut;
    w_hold_next = r_hold;
    if (w_oh) begin
      w_shut_next = 1'b1;
      w_hold_next = HOLD_LD;
    end else if (r_shut) begin
      if (r_hold == '0) begin
        w_shut_next = 1'b0;
      end else begin
        w_hold_next = r_hold - HW'(1);
      end
    end else begin
      w_hold_next = r_hold;
    end
  end

  assign w_rise = w_oh & ~r_prev_oh;

  // Saturating counter of overheat rising edges.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_rise && (r_cnt != {CNT_W{1'b1}})) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end else begin
      w_cnt_next = r_cnt;
    end
  end

  assign shut_off_computer = r_shut;
  assign keep_driving      = r_keep;
  assign drive_state       = r_state;
  assign overheat_count    = r_cnt;

endmodule

// File: tb/tb_alif2_ctrl.sv
// Self-checking bench for alif2_ctrl. It runs two instances on the same inputs:
// one with HOLD_CYCLES=0 and CNT_W=2, one with HOLD_CYCLES=4 and CNT_W=8.
// A behavioural model pushes the expected outputs to a scoreboard queue each cycle.
// Directed constant checks cover the sweep, hold length, counter and priority cases.
module tb_alif2_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_overheated = 1'b0;
  logic arrived = 1'b0;
  logic gas_tank_empty = 1'b0;

  logic       sh0, kd0, sh4, kd4;
  logic [1:0] ds0, ds4;
  logic [1:0] oc0;
  logic [7:0] oc4;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       sh0, kd0, sh4, kd4;
    logic [1:0] ds0, ds4;
    logic [1:0] oc0;
    logic [7:0] oc4;
  } exp_t;

  exp_t sb_q[$];

  // model state, index 0 -> u_dut0, index 1 -> u_dut4
  int   m_hold_ld[2] = '{0, 4};
  int   m_cnt_max[2] = '{3, 255};
  logic m_shut[2];
  int   m_hold[2];
  logic m_prev[2];
  int   m_cnt[2];
  int   m_ds[2];
  logic m_kd[2];
  logic [2:0] m_s1, m_s2;

  int ds_tab[8] = '{1, 3, 2, 2, 1, 3, 2, 2};

  always #5 clk = ~clk;

  alif2_ctrl #(.HOLD_CYCLES(0), .CNT_W(2)) u_dut0 (
    .clk(clk), .rst(rst), .cpu_overheated(cpu_overheated), .arrived(arrived),
    .gas_tank_empty(gas_tank_empty), .shut_off_computer(sh0), .keep_driving(kd0),
    .drive_state(ds0), .overheat_count(oc0)
  );

  alif2_ctrl #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .cpu_overheated(cpu_overheated), .arrived(arrived),
    .gas_tank_empty(gas_tank_empty), .shut_off_computer(sh4), .keep_driving(kd4),
    .drive_state(ds4), .overheat_count(oc4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_shut[k] = 1'b0; m_hold[k] = 0; m_prev[k] = 1'b0;
      m_cnt[k] = 0; m_ds[k] = 0; m_kd[k] = 1'b0;
    end
    m_s1 = 3'b000;
    m_s2 = 3'b000;
  endtask

  task automatic model_update(input int k, input logic [2:0] eff);
    logic oh, ar, ge;
    {oh, ar, ge} = eff;
    m_ds[k] = ar ? 2 : (ge ? 3 : 1);
    m_kd[k] = !ar && !ge;
    if (oh) begin
      m_shut[k] = 1'b1;
      m_hold[k] = m_hold_ld[k];
    end else if (m_shut[k]) begin
      if (m_hold[k] == 0) m_shut[k] = 1'b0;
      else m_hold[k] = m_hold[k] - 1;
    end
    if (oh && !m_prev[k] && m_cnt[k] < m_cnt_max[k]) m_cnt[k] = m_cnt[k] + 1;
    m_prev[k] = oh;
  endtask

  // one clock of stimulus: drive, predict, wait, compare against scoreboard
  task automatic step(input logic [2:0] v);
    logic [2:0] eff;
    exp_t e;
    exp_t g;
    {cpu_overheated, arrived, gas_tank_empty} = v;
`ifdef ALIF2_SYNC_EN
    eff  = m_s2;
    m_s2 = m_s1;
    m_s1 = v;
`else
    eff = v;
`endif
    for (int k = 0; k < 2; k++) model_update(k, eff);
    e.sh0 = m_shut[0]; e.kd0 = m_kd[0]; e.ds0 = 2'(m_ds[0]); e.oc0 = 2'(m_cnt[0]);
    e.sh4 = m_shut[1]; e.kd4 = m_kd[1]; e.ds4 = 2'(m_ds[1]); e.oc4 = 8'(m_cnt[1]);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    chk("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      g = sb_q.pop_front();
      chk("sh0", 32'(sh0), 32'(g.sh0));
      chk("kd0", 32'(kd0), 32'(g.kd0));
      chk("ds0", 32'(ds0), 32'(g.ds0));
      chk("oc0", 32'(oc0), 32'(g.oc0));
      chk("sh4", 32'(sh4), 32'(g.sh4));
      chk("kd4", 32'(kd4), 32'(g.kd4));
      chk("ds4", 32'(ds4), 32'(g.ds4));
      chk("oc4", 32'(oc4), 32'(g.oc4));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sh0"}, 32'(sh0), 32'd0);
    chk({tag, "_kd0"}, 32'(kd0), 32'd0);
    chk({tag, "_ds0"}, 32'(ds0), 32'd0);
    chk({tag, "_oc0"}, 32'(oc0), 32'd0);
    chk({tag, "_sh4"}, 32'(sh4), 32'd0);
    chk({tag, "_kd4"}, 32'(kd4), 32'd0);
    chk({tag, "_ds4"}, 32'(ds4), 32'd0);
    chk({tag, "_oc4"}, 32'(oc4), 32'd0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    sb_q.delete();
    for (int i = 0; i < n; i++) begin
      {cpu_overheated, arrived, gas_tank_empty} = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
      chk_all_zero("rst");
    end
    rst = 1'b0;
  endtask

  initial begin
    int hi;
    model_reset();

    // reset with random inputs, then release and follow the inputs
    do_reset(3);
    for (int i = 0; i < 6; i++) step(3'($urandom_range(0, 7)));

    // exhaustive sweep, 5 cycles per combination
    do_reset(1);
    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < 5; c++) step(3'(v));
      chk("sw_kd", 32'(kd0), (v == 0 || v == 4) ? 32'd1 : 32'd0);
      chk("sw_ds", 32'(ds0), 32'(ds_tab[v]));
      chk("sw_sh", 32'(sh0), (v >= 4) ? 32'd1 : 32'd0);
    end

    // hold: two cycles high, then low
    do_reset(1);
    hi = 0;
    step(3'b100); if (sh4) hi++;
    step(3'b100); if (sh4) hi++;
    for (int i = 0; i < 12; i++) begin
      step(3'b000);
      if (sh4) hi++;
    end
    chk("hold_len", 32'(hi), 32'd6);
    chk("hold_end", 32'(sh4), 32'd0);

    // hold restarted by re-assertion on the third low cycle
    do_reset(1);
    hi = 0;
    step(3'b100); if (sh4) hi++;
    for (int i = 0; i < 3; i++) begin step(3'b000); if (sh4) hi++; end
    step(3'b100); if (sh4) hi++;
    for (int i = 0; i < 12; i++) begin step(3'b000); if (sh4) hi++; end
    chk("rehold_len", 32'(hi), 32'd9);

    // counter and saturation
    do_reset(1);
    for (int p = 0; p < 3; p++) begin step(3'b100); step(3'b000); step(3'b000); end
    for (int i = 0; i < 3; i++) step(3'b000);
    chk("cnt3_w8", 32'(oc4), 32'd3);
    chk("cnt3_w2", 32'(oc0), 32'd3);
    for (int p = 0; p < 2; p++) begin step(3'b100); step(3'b000); step(3'b000); end
    for (int i = 0; i < 3; i++) step(3'b000);
    chk("cnt5_w8", 32'(oc4), 32'd5);
    chk("cnt5_sat", 32'(oc0), 32'd3);

    // priority: arrived over empty tank
    for (int i = 0; i < 4; i++) step(3'b011);
    chk("pri_ds", 32'(ds4), 32'd2);
    chk("pri_kd", 32'(kd4), 32'd0);
    for (int i = 0; i < 4; i++) step(3'b001);
    chk("nogas_ds", 32'(ds4), 32'd3);

    // asynchronous reset in the middle of a hold
    do_reset(1);
    step(3'b100);
    for (int i = 0; i < 3; i++) step(3'b000);
    chk("pre_rst_sh4", 32'(sh4), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("arst");
    do_reset(2);
    for (int i = 0; i < 4; i++) step(3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
